// File: rtl/lock_pkg.sv
// Shared types and helpers for the lock code checker: state encoding, key index width
// and a one-hot key decoder.
package lock_pkg;

  localparam int NUM_KEYS = 4;
  localparam int KEY_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  typedef enum logic [2:0] {
    ENTRY   = 3'b001,
    OPEN    = 3'b010,
    LOCKOUT = 3'b100,
    PROG    = 3'b011
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [KEY_W-1:0] idx;
  } key_dec_t;

  // valid only when exactly one flag is set; idx is that flag's position
  function automatic key_dec_t key_decode(input logic [NUM_KEYS-1:0] flags);
    key_dec_t d;
    int       ones;
    d    = '0;
    ones = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (flags[i]) begin
        ones++;
        d.idx = KEY_W'(i);
      end
    end
    d.valid = (ones == 1);
    return d;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock hold and lockout intervals; parks at zero.
module lock_timer #(
  parameter int W = 32
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Rst)                    cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lock_code_checker.sv
// Assembles debounced key pulses into code entries, opens the lock on a match and locks
// out after repeated failures. LOCK_CODE_PROG_EN adds in-field code reprogramming.
module lock_code_checker
  import lock_pkg::*;
#(
  parameter int                        CODE_LEN       = 4,
  parameter logic [CODE_LEN*KEY_W-1:0] CODE           = {2'd1, 2'd3, 2'd0, 2'd2},
  parameter int                        MAX_FAIL       = 3,
  parameter int                        UNLOCK_CYCLES  = 50_000_000,
  parameter int                        LOCKOUT_CYCLES = 500_000_000
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [NUM_KEYS-1:0]             key_flag,
  input  logic                            clr_flag,
`ifdef LOCK_CODE_PROG_EN
  input  logic                            prog_flag,
`endif
  output logic                            unlock,
  output logic                            err_pulse,
  output logic                            locked_out,
  output logic [$clog2(CODE_LEN+1)-1:0]   digit_cnt,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int CW   = CODE_LEN * KEY_W;
  localparam int DW   = $clog2(CODE_LEN + 1);
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [DW-1:0] LAST = DW'(CODE_LEN - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   entry_q, entry_d, shifted, code_q;
  logic [DW-1:0]   digit_d;
  logic [FW-1:0]   fail_d, fail_inc;
  logic            err_d, multi, last;
  logic            t_load, t_en, t_zero;
  logic [TW-1:0]   t_val;
  key_dec_t        kd;

`ifdef LOCK_CODE_PROG_EN
  logic [CW-1:0] code_d;
  always_ff @(posedge Clk) begin
    if (Rst) code_q <= CODE;
    else     code_q <= code_d;
  end
`else
  assign code_q = CODE;
`endif

  assign kd       = key_decode(key_flag);
  assign multi    = (|key_flag) && !kd.valid;
  assign shifted  = {entry_q[CW-KEY_W-1:0], kd.idx};
  assign last     = (digit_cnt == LAST);
  assign fail_inc = fail_cnt + FW'(1);
  assign t_en     = (state_q == OPEN) || (state_q == LOCKOUT);

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    digit_d = digit_cnt;
    fail_d  = fail_cnt;
    err_d   = 1'b0;
    t_load  = 1'b0;
    t_val   = '0;
`ifdef LOCK_CODE_PROG_EN
    code_d  = code_q;
`endif
    case (state_q)
      ENTRY: begin
        if (clr_flag) begin
          entry_d = '0;
          digit_d = '0;
        end else if (multi) begin
          err_d = 1'b1;
        end else if (kd.valid) begin
          if (!last) begin
            entry_d = shifted;
            digit_d = digit_cnt + DW'(1);
          end else begin
            entry_d = '0;
            digit_d = '0;
            if (shifted == code_q) begin
              state_d = OPEN;
              t_load  = 1'b1;
              t_val   = TW'(UNLOCK_CYCLES - 1);
              fail_d  = '0;
            end else begin
              err_d = 1'b1;
              if (fail_inc == FW'(MAX_FAIL)) begin
                state_d = LOCKOUT;
                t_load  = 1'b1;
                t_val   = TW'(LOCKOUT_CYCLES - 1);
                fail_d  = '0;
              end else begin
                fail_d = fail_inc;
              end
            end
          end
        end
      end
      OPEN: begin
`ifdef LOCK_CODE_PROG_EN
        if (prog_flag) state_d = PROG;
        else
`endif
        if (t_zero) state_d = ENTRY;
      end
      LOCKOUT: begin
        if (t_zero) state_d = ENTRY;
      end
`ifdef LOCK_CODE_PROG_EN
      // timer is not enabled here, so the unlock hold resumes nowhere: exit always drops unlock
      PROG: begin
        if (clr_flag) begin
          state_d = ENTRY;
          entry_d = '0;
          digit_d = '0;
        end else if (kd.valid) begin
          if (!last) begin
            entry_d = shifted;
            digit_d = digit_cnt + DW'(1);
          end else begin
            code_d  = shifted;
            state_d = ENTRY;
            entry_d = '0;
            digit_d = '0;
          end
        end
      end
`endif
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ENTRY;
      entry_q    <= '0;
      digit_cnt  <= '0;
      fail_cnt   <= '0;
      err_pulse  <= 1'b0;
      unlock     <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      digit_cnt  <= digit_d;
      fail_cnt   <= fail_d;
      err_pulse  <= err_d;
      unlock     <= (state_d == OPEN) || (state_d == PROG);
      locked_out <= (state_d == LOCKOUT);
    end
  end

  lock_timer #(.W(TW)) u_timer (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .zero     (t_zero)
  );

endmodule
